// File: rtl/stack_ptr_unit.sv
// stack_ptr_unit: downward-growing stack pointer with bounded push/pop, load, shadow save/restore and sticky faults
module stack_ptr_unit #(
  parameter int          ADDR_W      = 14,
  parameter int          STEP_W      = 3,
  parameter int unsigned STACK_TOP   = 2**ADDR_W - 1,
  parameter int unsigned STACK_LIMIT = 2**ADDR_W - 256
) (
  input  logic              clk,
  input  logic              rst_async_n,
  input  logic [2:0]        op,
  input  logic [STEP_W-1:0] step,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              fault_clr,
  output logic [ADDR_W-1:0] sp_addr,
  output logic [ADDR_W-1:0] depth,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              illegal_op,
  output logic              fault_pulse
);
  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_PUSH    = 3'b001,
    OP_POP     = 3'b010,
    OP_LOAD    = 3'b011,
    OP_SAVE    = 3'b100,
    OP_RESTORE = 3'b101,
    OP_ILL6    = 3'b110,
    OP_ILL7    = 3'b111
  } op_t;
  localparam logic [ADDR_W:0]   TOP_X = (ADDR_W+1)'(STACK_TOP);
  localparam logic [ADDR_W:0]   LIM_X = (ADDR_W+1)'(STACK_LIMIT);
  localparam logic [ADDR_W-1:0] TOP_A = ADDR_W'(STACK_TOP);
  localparam logic [ADDR_W-1:0] LIM_A = ADDR_W'(STACK_LIMIT);
  op_t               opc;
  logic [ADDR_W-1:0] shadow, sp_nx, shadow_nx;
  logic [ADDR_W:0]   sp_x, step_x, ld_x, push_c, pop_c;
  logic              push_bad, pop_bad, ld_ovf, ld_unf;
  logic              ovf_ev, unf_ev, ill_ev;
  assign opc    = op_t'(op);
  assign sp_x   = {1'b0, sp_addr};
  assign step_x = (ADDR_W+1)'(step);
  assign ld_x   = {1'b0, load_value};
  assign push_c = sp_x - step_x;
  assign pop_c  = sp_x + step_x;
  // a borrow out of the subtraction also means the candidate fell below the limit
  assign push_bad = push_c[ADDR_W] || (push_c < LIM_X);
  assign pop_bad  = pop_c > TOP_X;
  assign ld_ovf   = ld_x < LIM_X;
  assign ld_unf   = ld_x > TOP_X;
  assign depth    = TOP_A - sp_addr;
  assign empty    = sp_addr == TOP_A;
  assign full     = sp_addr == LIM_A;
  // next SP/shadow and fault events; rejected ops leave SP and shadow untouched
  always_comb begin
    sp_nx     = sp_addr;
    shadow_nx = shadow;
    ovf_ev    = 1'b0;
    unf_ev    = 1'b0;
    ill_ev    = 1'b0;
    case (opc)
      OP_PUSH: begin
        ovf_ev = push_bad;
        sp_nx  = push_bad ? sp_addr : push_c[ADDR_W-1:0];
      end
      OP_POP: begin
        unf_ev = pop_bad;
        sp_nx  = pop_bad ? sp_addr : pop_c[ADDR_W-1:0];
      end
      OP_LOAD: begin
        ovf_ev = ld_ovf;
        unf_ev = ld_unf;
        sp_nx  = (ld_ovf || ld_unf) ? sp_addr : load_value;
      end
      OP_SAVE:    shadow_nx = sp_addr;
      OP_RESTORE: sp_nx     = shadow;
      OP_ILL6, OP_ILL7: ill_ev = 1'b1;
      default: ;
    endcase
  end
  // state update; a new fault outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      sp_addr     <= TOP_A;
      shadow      <= TOP_A;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      illegal_op  <= 1'b0;
      fault_pulse <= 1'b0;
    end else begin
      sp_addr     <= sp_nx;
      shadow      <= shadow_nx;
      overflow    <= ovf_ev || (overflow && !fault_clr);
      underflow   <= unf_ev || (underflow && !fault_clr);
      illegal_op  <= ill_ev || (illegal_op && !fault_clr);
      fault_pulse <= ovf_ev || unf_ev || ill_ev;
    end
  end
endmodule

// File: tb/tb_stack_ptr_unit.sv
// tb_stack_ptr_unit: directed scoreboard bench for stack_ptr_unit with default parameters
module tb_stack_ptr_unit;
  localparam int AW = 14;
  localparam int SW = 3;
  logic          clk = 1'b0;
  logic          rst_async_n;
  logic [2:0]    op;
  logic [SW-1:0] step;
  logic [AW-1:0] load_value;
  logic          fault_clr;
  logic [AW-1:0] sp_addr, depth;
  logic          empty, full, overflow, underflow, illegal_op, fault_pulse;
  int            n_cmp = 0;
  int            n_bad = 0;
  typedef struct {
    string         name;
    logic [AW-1:0] sp;
    logic          ovf, unf, ill, pul;
  } exp_t;
  exp_t q[$];
  stack_ptr_unit dut (
    .clk(clk), .rst_async_n(rst_async_n), .op(op), .step(step),
    .load_value(load_value), .fault_clr(fault_clr), .sp_addr(sp_addr),
    .depth(depth), .empty(empty), .full(full), .overflow(overflow),
    .underflow(underflow), .illegal_op(illegal_op), .fault_pulse(fault_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic apply(input string name, input logic [2:0] o, input int s, input int lv,
                       input logic clr, input int esp, input logic eo, input logic eu,
                       input logic ei, input logic ep);
    exp_t e;
    @(negedge clk);
    op = o;
    step = SW'(s);
    load_value = AW'(lv);
    fault_clr = clr;
    e.name = name;
    e.sp = AW'(esp);
    e.ovf = eo;
    e.unf = eu;
    e.ill = ei;
    e.pul = ep;
    q.push_back(e);
  endtask
  // monitor: every edge following an issued op, compare the registered result
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.name, ".sp"}, int'(sp_addr), int'(e.sp));
        chk({e.name, ".depth"}, int'(depth), 16383 - int'(e.sp));
        chk({e.name, ".empty"}, int'(empty), int'(e.sp == 14'd16383));
        chk({e.name, ".full"}, int'(full), int'(e.sp == 14'd16128));
        chk({e.name, ".ovf"}, int'(overflow), int'(e.ovf));
        chk({e.name, ".unf"}, int'(underflow), int'(e.unf));
        chk({e.name, ".ill"}, int'(illegal_op), int'(e.ill));
        chk({e.name, ".pulse"}, int'(fault_pulse), int'(e.pul));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d pending", q.size());
    $fatal(1, "watchdog");
  end
  initial begin
    rst_async_n = 1'b0;
    op = 3'b001;
    step = 3'd4;
    load_value = '0;
    fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.sp", int'(sp_addr), 16383);
    chk("rst.depth", int'(depth), 0);
    chk("rst.empty", int'(empty), 1);
    chk("rst.flags", int'({overflow, underflow, illegal_op, fault_pulse}), 0);
    @(negedge clk);
    op = 3'b000;
    rst_async_n = 1'b1;
    apply("push2a", 3'b001, 2, 0, 0, 16381, 0, 0, 0, 0);
    apply("push2b", 3'b001, 2, 0, 0, 16379, 0, 0, 0, 0);
    apply("push2c", 3'b001, 2, 0, 0, 16377, 0, 0, 0, 0);
    apply("pop3a", 3'b010, 3, 0, 0, 16380, 0, 0, 0, 0);
    apply("pop3b", 3'b010, 3, 0, 0, 16383, 0, 0, 0, 0);
    apply("pop_empty", 3'b010, 1, 0, 0, 16383, 0, 1, 0, 1);
    apply("hold_unf", 3'b000, 0, 0, 0, 16383, 0, 1, 0, 0);
    apply("clr_unf", 3'b000, 0, 0, 1, 16383, 0, 0, 0, 0);
    apply("load16129", 3'b011, 0, 16129, 0, 16129, 0, 0, 0, 0);
    apply("push_full", 3'b001, 1, 0, 0, 16128, 0, 0, 0, 0);
    apply("push_ovf", 3'b001, 2, 0, 0, 16128, 1, 0, 0, 1);
    apply("load_low", 3'b011, 0, 16000, 0, 16128, 1, 0, 0, 1);
    apply("clr_ovf", 3'b000, 0, 0, 1, 16128, 0, 0, 0, 0);
    apply("push_zero", 3'b001, 0, 0, 0, 16128, 0, 0, 0, 0);
    apply("load16200", 3'b011, 0, 16200, 0, 16200, 0, 0, 0, 0);
    apply("save", 3'b100, 0, 0, 0, 16200, 0, 0, 0, 0);
    apply("push7", 3'b001, 7, 0, 0, 16193, 0, 0, 0, 0);
    apply("restore", 3'b101, 0, 0, 0, 16200, 0, 0, 0, 0);
    apply("ill_a", 3'b111, 0, 0, 0, 16200, 0, 0, 1, 1);
    apply("ill_clr", 3'b111, 0, 0, 1, 16200, 0, 0, 1, 1);
    apply("ill_hold", 3'b000, 0, 0, 0, 16200, 0, 0, 1, 0);
    apply("ill6", 3'b110, 0, 0, 0, 16200, 0, 0, 1, 1);
    apply("load16380", 3'b011, 0, 16380, 0, 16380, 0, 0, 1, 0);
    apply("pop_unf_clr", 3'b010, 7, 0, 1, 16380, 0, 1, 0, 1);
    apply("unf_hold", 3'b000, 0, 0, 0, 16380, 0, 1, 0, 0);
    apply("clr_unf2", 3'b000, 0, 0, 1, 16380, 0, 0, 0, 0);
    apply("load16300", 3'b011, 0, 16300, 0, 16300, 0, 0, 0, 0);
    apply("save2", 3'b100, 0, 0, 0, 16300, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    op = 3'b000;
    rst_async_n = 1'b0;
    #1;
    chk("async.sp", int'(sp_addr), 16383);
    chk("async.depth", int'(depth), 0);
    @(negedge clk);
    rst_async_n = 1'b1;
    apply("restore_rst", 3'b101, 0, 0, 0, 16383, 0, 0, 0, 0);
    apply("tail", 3'b000, 0, 0, 0, 16383, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_ptr_unit.md
Name: stack_ptr_unit

Overview:
Parametrised stack pointer and SP ALU for the next-generation CPU core. Holds the stack pointer for a downward-growing stack confined to [STACK_LIMIT, STACK_TOP].
- Supports variable-size push/pop, direct load, and a one-deep shadow save/restore for interrupt entry/exit.
- Detects overflow, underflow and illegal operations without corrupting SP.
- Sits beside the control unit; sp_addr feeds the memory address mux.

Parameters:
ADDR_W, 14, width of the stack pointer / address bus
STEP_W, 3, width of the push/pop step operand (max step 2^STEP_W-1)
STACK_TOP, 2^ADDR_W-1, reset value of SP; empty-stack address (highest legal SP)
STACK_LIMIT, 2^ADDR_W-256, lowest legal SP (full-stack address)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_async_n  in  1  asynchronous active-low reset
op  in  3  operation: 000 NOP, 001 PUSH, 010 POP, 011 LOAD, 100 SAVE, 101 RESTORE, 110/111 illegal
step  in  STEP_W  bytes to push/pop; used only by PUSH/POP
load_value  in  ADDR_W  new SP for LOAD
fault_clr  in  1  clears all sticky fault flags
sp_addr  out  ADDR_W  current stack pointer
depth  out  ADDR_W  STACK_TOP - sp_addr (0 = empty)
empty  out  1  sp_addr == STACK_TOP
full  out  1  sp_addr == STACK_LIMIT
overflow  out  1  sticky: PUSH or LOAD below STACK_LIMIT rejected
underflow  out  1  sticky: POP or LOAD above STACK_TOP rejected
illegal_op  out  1  sticky: op 110/111 received
fault_pulse  out  1  one-cycle strobe in the cycle after any rejected op

Behaviour:
- Reset (rst_async_n low, asynchronous assert):
  - sp_addr = STACK_TOP; shadow register = STACK_TOP.
  - overflow = underflow = illegal_op = fault_pulse = 0.
  - Deassertion takes effect at the next rising edge; an op presented in the reset cycle is discarded.
- All ops are single-cycle: the new SP is visible on sp_addr the cycle after op is sampled. depth, empty and full are combinational from sp_addr.
- Arithmetic is done in ADDR_W+1 bits with step zero-extended. Bounds checks compare against the unwrapped result, so SP never wraps modulo 2^ADDR_W.
- PUSH: candidate = sp - step.
  - candidate < STACK_LIMIT: SP unchanged, overflow set, fault_pulse.
  - Otherwise SP = candidate.
- POP: candidate = sp + step.
  - candidate > STACK_TOP: SP unchanged, underflow set, fault_pulse.
  - Otherwise SP = candidate.
- PUSH/POP with step = 0 behave as NOP. No fault.
- LOAD:
  - load_value < STACK_LIMIT: rejected, overflow set.
  - load_value > STACK_TOP: rejected, underflow set.
  - Otherwise SP = load_value.
- SAVE: shadow = sp; SP unchanged.
- RESTORE: SP = shadow; shadow unchanged. Shadow is always in range, so RESTORE never faults.
- Illegal op: SP and shadow unchanged, illegal_op set, fault_pulse.
- Sticky flags:
  - Once set, they hold until fault_clr or reset.
  - If fault_clr and a new fault occur in the same cycle, the new fault wins: the flag ends up 1 and the other flags clear.
  - fault_clr does not affect SP.
- fault_pulse is high for exactly one cycle per rejected op. Back-to-back rejected ops keep it high continuously.
- No X propagation: every op code has a defined result.

Test Plan:
- Reset with defaults (ADDR_W=14): hold rst_async_n low -> sp_addr=16383, depth=0, empty=1, all flags 0. Assert reset mid-run with sp=16300 -> sp_addr returns to 16383 immediately, without waiting for a clock edge.
- PUSH step=2 ×3 from reset -> sp 16381, 16379, 16377, depth=6. Then POP step=3, POP step=3 -> 16380, 16383, empty=1.
- Underflow at empty: POP step=1 -> sp stays 16383, underflow=1, fault_pulse for one cycle. Then fault_clr -> underflow=0.
- Overflow: LOAD 16129, PUSH step=1 -> sp=16128, full=1. Then PUSH step=2 -> sp stays 16128, overflow=1. Then LOAD 16000 -> rejected, overflow stays 1.
- Shadow: LOAD 16200, SAVE, PUSH step=7 -> sp=16193. Then RESTORE -> sp=16200. Reset, then RESTORE -> sp=16383.
- Illegal/simultaneous: op=111 -> sp unchanged, illegal_op=1. Then op=111 with fault_clr=1 -> illegal_op remains 1 and fault_pulse stays high continuously across both cycles.
